hidden_reg_bank: RTL and testbench
==================================

Name: hidden_reg_bank

Overview:
Parametrised holding bank for hidden-layer neuron outputs. The neuron array computes GROUP_SIZE activations per pass. This block captures successive groups into consecutive lane slices under a valid/ready handshake, tracks which group is next, and presents the full concatenated vector to the output layer with its own valid/ready handshake. It sits between the hidden-layer compute datapath and the output-layer MAC stage, and replaces fixed two-group register wiring with a counted, flow-controlled bank.

Parameters:
WIDTH, 8, bits per neuron activation
NUM_NEURONS, 20, total hidden neurons held
GROUP_SIZE, 10, activations delivered per input transfer
(localparam NUM_GROUPS = ceil(NUM_NEURONS/GROUP_SIZE); GRP_W = max(1, clog2(NUM_GROUPS)))

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
clr  input  1  synchronous abort of current fill, no data clear
in_valid  input  1  in_data holds one group
in_ready  output  1  bank accepts a group this cycle
in_data  input  GROUP_SIZE*WIDTH  group lanes, lane k at bits [k*WIDTH +: WIDTH]
grp_idx  output  GRP_W  index of next group to be written
out_valid  output  1  out_concat holds a complete vector
out_ready  input  1  consumer takes the vector
out_concat  output  NUM_NEURONS*WIDTH  neuron n at bits [n*WIDTH +: WIDTH], neuron 0 in LSBs

Behaviour:
- One clock domain. Reset is synchronous and active-high. Ports are named clk and rst.
- State machine with two states, FILL and FULL.
- Reset (rst=1 at an edge): state=FILL, grp_idx=0, all neuron registers=0, in_ready=1, out_valid=0, out_concat=0.
- in_ready = (state==FILL) and is combinational from state. out_valid = (state==FULL) and is registered.
- FILL, on in_valid && in_ready: lane k is written to neuron grp_idx*GROUP_SIZE+k for every k where that index < NUM_NEURONS.
  - Lanes beyond NUM_NEURONS in the final partial group are ignored.
  - Neurons outside the addressed group hold their value.
- FILL, group accepted and grp_idx < NUM_GROUPS-1: grp_idx increments and the state stays FILL.
- FILL, group accepted and grp_idx == NUM_GROUPS-1: grp_idx wraps to 0 and the state goes to FULL. out_valid rises on the next cycle, one cycle after the last write edge.
- FILL, in_valid=0: no change.
- FULL: in_ready=0 and in_valid is ignored. out_concat is stable while out_valid=1.
- FULL, out_ready=1: state returns to FILL and out_valid falls the next cycle. Registers keep their contents; the next fill overwrites them group by group.
- FULL, out_ready=0: the state holds indefinitely.
- out_concat always reflects the registers directly, including during FILL. Consumers qualify it with out_valid.
- clr=1 at an edge: state=FILL, grp_idx=0. Registers are not cleared.
  - clr has priority over a simultaneous input transfer; that data is dropped and grp_idx stays 0.
  - clr has priority over a simultaneous out_ready.
- rst has priority over clr and over both handshakes. Reset mid-fill discards partial data.
- Throughput: one group per cycle in FILL. Minimum period per vector is NUM_GROUPS+1 cycles (fill plus one FULL cycle with out_ready=1).
- NUM_GROUPS==1 is legal. A single transfer goes straight to FULL, and grp_idx is held at 0.

Test Plan:
- Default params, after rst: out_concat=0, in_ready=1, out_valid=0, grp_idx=0.
- Normal fill: send group0 lanes = 8'h01..8'h0A, then group1 = 8'h11..8'h1A on consecutive cycles with out_ready=0 → out_concat[7:0]=01, [79:72]=0A, [87:80]=11, [159:152]=1A; out_valid=1 one cycle after the second write; in_ready=0.
- Backpressure and drain: hold out_ready=0 for 5 cycles → out_concat unchanged and extra in_valid pulses (data 8'hFF) ignored. Then out_ready=1 for one cycle → out_valid=0, in_ready=1, grp_idx=0, out_concat still holds the old values.
- Partial last group: NUM_NEURONS=15, GROUP_SIZE=10, second group lanes all 8'hAA → neurons 10..14 = AA, out_concat width 120, lanes 5..9 ignored, out_valid asserts.
- clr mid-fill: after group0 is written, assert clr together with in_valid (data 8'h55) → grp_idx=0, state FILL, data dropped. The next two transfers complete the vector normally.
- Reset priority: rst with clr, in_valid and out_ready all high, while in FULL → all registers 0, out_valid=0, in_ready=1 the next cycle.

Source files
------------

// File: rtl/hidden_reg_bank.sv
// Holding bank for hidden-layer activations. Groups of GROUP_SIZE lanes are
// captured into consecutive neuron slots under a valid/ready handshake. Once
// every group is in, the whole vector is offered to the output layer, also
// under a valid/ready handshake.
module hidden_reg_bank #(
  parameter int WIDTH       = 8,
  parameter int NUM_NEURONS = 20,
  parameter int GROUP_SIZE  = 10,
  localparam int NUM_GROUPS = (NUM_NEURONS + GROUP_SIZE - 1) / GROUP_SIZE,
  localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [GROUP_SIZE*WIDTH-1:0]  in_data,
  output logic [GRP_W-1:0]             grp_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_NEURONS*WIDTH-1:0] out_concat
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);

  state_t           state_q, state_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic             wr_en;

  // A group is only written when the bank is filling and no abort is pending.
  assign in_ready  = (state_q == FILL);
  assign wr_en     = in_valid && in_ready && !clr;
  assign out_valid = (state_q == FULL);
  assign grp_idx   = grp_q;

  // Next-state and group-counter logic; clr overrides both handshakes.
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    if (clr) begin
      state_d = FILL;
      grp_d   = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid) begin
            if (grp_q == LAST_GRP) begin
              grp_d   = '0;
              state_d = FULL;
            end else begin
              grp_d = grp_q + GRP_W'(1);
            end
          end
        end
        FULL: begin
          if (out_ready) state_d = FILL;
        end
        default: state_d = FILL;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      grp_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
    end
  end

  // One register per neuron. Its group and lane are fixed at elaboration,
  // so unused lanes of a trailing partial group never reach any register.
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    localparam int GRP  = n / GROUP_SIZE;
    localparam int LANE = n % GROUP_SIZE;

    logic [WIDTH-1:0] neur_q;

    // Capture this neuron's lane when its group is the one being written.
    always_ff @(posedge clk) begin
      if (rst) begin
        neur_q <= '0;
      end else if (wr_en && (grp_q == GRP_W'(GRP))) begin
        neur_q <= in_data[LANE*WIDTH +: WIDTH];
      end
    end

    assign out_concat[n*WIDTH +: WIDTH] = neur_q;
  end

endmodule

// File: tb/tb_hidden_reg_bank.sv
// Directed bench for hidden_reg_bank: default 20x8 bank plus a 15-neuron bank
// whose last group is partial. Expected vectors go into a scoreboard queue as
// the final group of a fill is driven and are popped when out_valid is seen.
module tb_hidden_reg_bank;

  logic clk = 1'b0;
  logic rst, clr;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [79:0]  a_in_data;
  logic [0:0]   a_grp_idx;
  logic [159:0] a_out_concat;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [79:0]  b_in_data;
  logic [0:0]   b_grp_idx;
  logic [119:0] b_out_concat;

  int checks = 0;
  int errors = 0;
  logic [159:0] sb_q[$];
  logic [159:0] exp_v, held_v;

  always #5 clk = ~clk;

  hidden_reg_bank #(.WIDTH(8), .NUM_NEURONS(20), .GROUP_SIZE(10)) dut_a (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .grp_idx(a_grp_idx), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_concat(a_out_concat)
  );

  hidden_reg_bank #(.WIDTH(8), .NUM_NEURONS(15), .GROUP_SIZE(10)) dut_b (
    .clk(clk), .rst(rst), .clr(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .grp_idx(b_grp_idx), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_concat(b_out_concat)
  );

  function automatic logic [79:0] ramp(input logic [7:0] base);
    logic [79:0] v;
    for (int k = 0; k < 10; k++) v[k*8 +: 8] = base + 8'(k);
    return v;
  endfunction

  function automatic logic [79:0] fill8(input logic [7:0] b);
    logic [79:0] v;
    for (int k = 0; k < 10; k++) v[k*8 +: 8] = b;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare a presented vector against the oldest scoreboard entry.
  task automatic sb_pop(input string tag, input logic vld, input logic [159:0] obs);
    chk({tag, "_valid"}, 160'(vld), 160'(1));
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      exp_v = sb_q.pop_front();
      chk({tag, "_vec"}, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    chk("rst_concat", a_out_concat, '0);
    chk("rst_in_ready", 160'(a_in_ready), 160'(1));
    chk("rst_out_valid", 160'(a_out_valid), 160'(0));
    chk("rst_grp_idx", 160'(a_grp_idx), 160'(0));

    // Idle in FILL changes nothing.
    step();
    chk("idle_grp_idx", 160'(a_grp_idx), 160'(0));

    // Normal fill of two groups back to back.
    a_in_valid = 1'b1; a_in_data = ramp(8'h01);
    step();
    chk("fill_g0_grp_idx", 160'(a_grp_idx), 160'(1));
    chk("fill_g0_out_valid", 160'(a_out_valid), 160'(0));
    a_in_data = ramp(8'h11);
    sb_q.push_back({ramp(8'h11), ramp(8'h01)});
    step();
    a_in_valid = 1'b0;
    sb_pop("fill", a_out_valid, a_out_concat);
    chk("fill_byte0", 160'(a_out_concat[7:0]), 160'(8'h01));
    chk("fill_byte9", 160'(a_out_concat[79:72]), 160'(8'h0A));
    chk("fill_byte10", 160'(a_out_concat[87:80]), 160'(8'h11));
    chk("fill_byte19", 160'(a_out_concat[159:152]), 160'(8'h1A));
    chk("fill_in_ready", 160'(a_in_ready), 160'(0));
    chk("fill_grp_idx", 160'(a_grp_idx), 160'(0));

    // Backpressure: vector held, stray inputs ignored.
    held_v = {ramp(8'h11), ramp(8'h01)};
    a_in_valid = 1'b1; a_in_data = fill8(8'hFF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_concat", a_out_concat, held_v);
      chk("bp_out_valid", 160'(a_out_valid), 160'(1));
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    chk("drain_out_valid", 160'(a_out_valid), 160'(0));
    chk("drain_in_ready", 160'(a_in_ready), 160'(1));
    chk("drain_grp_idx", 160'(a_grp_idx), 160'(0));
    chk("drain_concat", a_out_concat, held_v);

    // clr mid-fill drops the simultaneous transfer.
    a_in_valid = 1'b1; a_in_data = ramp(8'h21);
    step();
    chk("clr_pre_grp_idx", 160'(a_grp_idx), 160'(1));
    clr = 1'b1; a_in_data = fill8(8'h55);
    step();
    clr = 1'b0;
    chk("clr_grp_idx", 160'(a_grp_idx), 160'(0));
    chk("clr_in_ready", 160'(a_in_ready), 160'(1));
    chk("clr_concat", a_out_concat, {ramp(8'h11), ramp(8'h21)});
    a_in_data = ramp(8'h31);
    step();
    a_in_data = ramp(8'h41);
    sb_q.push_back({ramp(8'h41), ramp(8'h31)});
    step();
    a_in_valid = 1'b0;
    sb_pop("refill", a_out_valid, a_out_concat);

    // Reset beats clr and both handshakes while FULL.
    rst = 1'b1; clr = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    step();
    rst = 1'b0; clr = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    chk("rstp_concat", a_out_concat, '0);
    chk("rstp_out_valid", 160'(a_out_valid), 160'(0));
    chk("rstp_in_ready", 160'(a_in_ready), 160'(1));
    chk("rstp_grp_idx", 160'(a_grp_idx), 160'(0));

    // Partial last group on the 15-neuron bank: lanes 5..9 of group 1 unused.
    b_in_valid = 1'b1; b_in_data = ramp(8'h61);
    step();
    b_in_data = fill8(8'hAA);
    sb_q.push_back(160'({40'hAAAAAAAAAA, ramp(8'h61)}));
    step();
    b_in_valid = 1'b0;
    sb_pop("partial", b_out_valid, 160'(b_out_concat));
    chk("partial_in_ready", 160'(b_in_ready), 160'(0));
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    chk("partial_drain_valid", 160'(b_out_valid), 160'(0));

    chk("sb_empty", 160'(sb_q.size()), 160'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
